// File: rtl/cdb_pkg.sv
// Shared constants and source identifiers for the common data bus arbiter.
package cdb_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_TAG_W  = 2;
  localparam int NUM_SRC    = 3;

  typedef enum logic [1:0] {
    SRC_ADD  = 2'd0,
    SRC_MULT = 2'd1,
    SRC_LD   = 2'd2
  } src_e;

  // Round-robin successor: add -> mult -> load -> add.
  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_ADD:  return SRC_MULT;
      SRC_MULT: return SRC_LD;
      default:  return SRC_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cdb_src_buf.sv
// One-entry holding register for a single result source.
// Priority at each edge: clear, then load (which also covers a same-edge drain), then drain.
module cdb_src_buf #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              drain,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_taken,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data,
  output logic              taken
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              taken_q, taken_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    taken_d = taken_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      tag_d   = in_tag;
      data_d  = in_data;
      taken_d = in_taken;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
    taken_q <= taken_d;
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign data  = data_q;
  assign taken = taken_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers one result per execution unit and broadcasts
// one per cycle to the ROB, granting round-robin among add, mult and load.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              add_valid,
  input  logic              mult_valid,
  input  logic              ld_valid,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [TAG_W-1:0]  mult_tag,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] mult_data,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              add_taken,
  output logic              add_ready,
  output logic              mult_ready,
  output logic              ld_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_rob_dest,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_taken,
  output logic [1:0]        cdb_src
);

  logic [NUM_SRC-1:0] in_valid, in_taken, ready, load, grant, clear_all;
  logic [NUM_SRC-1:0] buf_valid, buf_taken;
  logic [TAG_W-1:0]   in_tag   [NUM_SRC];
  logic [TAG_W-1:0]   buf_tag  [NUM_SRC];
  logic [DATA_W-1:0]  in_data  [NUM_SRC];
  logic [DATA_W-1:0]  buf_data [NUM_SRC];

  src_e grant_src;
  logic grant_any;

  src_e              last_q, last_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_dest_q, cdb_dest_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              cdb_taken_q, cdb_taken_d;
  logic [1:0]        cdb_src_q, cdb_src_d;

  assign in_valid = {ld_valid, mult_valid, add_valid};
  assign in_taken = {1'b0, 1'b0, add_taken};
  assign in_tag[SRC_ADD]   = add_tag;
  assign in_tag[SRC_MULT]  = mult_tag;
  assign in_tag[SRC_LD]    = ld_tag;
  assign in_data[SRC_ADD]  = add_data;
  assign in_data[SRC_MULT] = mult_data;
  assign in_data[SRC_LD]   = ld_data;

  // Search starts one past the last granted source.
  always_comb begin
    src_e cand;
    grant     = '0;
    grant_any = 1'b0;
    grant_src = last_q;
    cand      = last_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = next_src(cand);
      if (!grant_any && buf_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_src   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  // A buffer being drained this cycle can accept its replacement at the same edge.
  assign ready     = (~buf_valid | grant) & {NUM_SRC{~(flush | rst)}};
  assign load      = in_valid & ready;
  assign clear_all = {NUM_SRC{flush | rst}};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_buf
    cdb_src_buf #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_buf (
      .clk      (clk),
      .clear    (clear_all[g]),
      .load     (load[g]),
      .drain    (grant[g]),
      .in_tag   (in_tag[g]),
      .in_data  (in_data[g]),
      .in_taken (in_taken[g]),
      .valid    (buf_valid[g]),
      .tag      (buf_tag[g]),
      .data     (buf_data[g]),
      .taken    (buf_taken[g])
    );
  end

  // Broadcast register stage; a flush suppresses the grant and leaves the pointer alone.
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_dest_d  = cdb_dest_q;
    cdb_data_d  = cdb_data_q;
    cdb_taken_d = cdb_taken_q;
    cdb_src_d   = cdb_src_q;
    last_d      = last_q;
    if (grant_any && !flush) begin
      cdb_valid_d = 1'b1;
      cdb_dest_d  = buf_tag[grant_src];
      cdb_data_d  = buf_data[grant_src];
      cdb_taken_d = (grant_src == SRC_ADD) && buf_taken[grant_src];
      cdb_src_d   = grant_src;
      last_d      = grant_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_dest_q  <= '0;
      cdb_data_q  <= '0;
      cdb_taken_q <= 1'b0;
      cdb_src_q   <= 2'd0;
      last_q      <= SRC_LD;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_data_q  <= cdb_data_d;
      cdb_taken_q <= cdb_taken_d;
      cdb_src_q   <= cdb_src_d;
      last_q      <= last_d;
    end
  end

  assign add_ready    = ready[SRC_ADD];
  assign mult_ready   = ready[SRC_MULT];
  assign ld_ready     = ready[SRC_LD];
  assign cdb_valid    = cdb_valid_q;
  assign cdb_rob_dest = cdb_dest_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_taken    = cdb_taken_q;
  assign cdb_src      = cdb_src_q;

endmodule
